// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes board reset release, stretches it, then releases
// up to four domains in staggered order; handles warm resets and a slow-mode enable.
module rst_sequencer #(
    parameter int SYNC_DEPTH = 2,
    parameter int STRETCH    = 16,
    parameter int STAGES     = 3,
    parameter int STAGE_GAP  = 4,
    parameter int DIV        = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sw_rst_req,
    input  logic              wdt_bite,
    output logic              sw_rst_ack,
    output logic [STAGES-1:0] rstn_o,
    output logic              rst_busy,
    output logic              clk_en,
    output logic [1:0]        rst_cause
);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [15:0]   STRETCH_LAST = 16'(STRETCH - 1);
    localparam logic [7:0]    GAP_LAST     = 8'(STAGE_GAP - 1);
    localparam logic [1:0]    STAGE_LAST   = 2'(STAGES - 1);
    localparam logic [DW-1:0] DIV_LAST     = DW'(DIV - 1);

    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [1:0]            state_q, state_d;
    logic [15:0]           str_cnt_q, str_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic [1:0]            stage_q, stage_d;
    logic [1:0]            stage_nxt;
    logic [STAGES-1:0]     rstn_q, rstn_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic [1:0]            cause_q, cause_d;
    logic [DW-1:0]         div_cnt_q, div_cnt_d;
    logic                  en_q, en_d;

    assign stage_nxt = stage_q + 2'd1;

    always_comb begin
        sync_d    = {sync_q[SYNC_DEPTH-2:0], 1'b1};
        state_d   = state_q;
        str_cnt_d = str_cnt_q;
        gap_cnt_d = gap_cnt_q;
        stage_d   = stage_q;
        rstn_d    = rstn_q;
        cause_d   = cause_q;
        case (state_q)
            ST_ASSERT: begin
                rstn_d    = '0;
                str_cnt_d = '0;
                if (sync_q[SYNC_DEPTH-1]) state_d = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (str_cnt_q == STRETCH_LAST) begin
                    rstn_d    = STAGES'(1);
                    gap_cnt_d = '0;
                    stage_d   = '0;
                    state_d   = (STAGES == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    str_cnt_d = str_cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // rstn is a thermometer code: shifting in a 1 frees the next domain
                    rstn_d    = STAGES'({rstn_q, 1'b1});
                    gap_cnt_d = '0;
                    stage_d   = stage_nxt;
                    if (stage_nxt == STAGE_LAST) state_d = ST_RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                if (wdt_bite || sw_rst_req) begin
                    rstn_d  = '0;
                    state_d = ST_ASSERT;
                    cause_d = wdt_bite ? 2'b11 : 2'b10;
                end
            end
        endcase
        busy_d = ~&rstn_d;
        // ASSERT with a software cause only follows an accepted warm reset and lasts one cycle
        ack_d  = (state_q == ST_ASSERT) && (cause_q == 2'b10);
    end

    always_comb begin
        div_cnt_d = '0;
        if (rstn_d[0] && rstn_q[0])
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        en_d = rstn_d[0] && (div_cnt_d == DIV_LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q    <= '0;
            state_q   <= ST_ASSERT;
            str_cnt_q <= '0;
            gap_cnt_q <= '0;
            stage_q   <= '0;
            rstn_q    <= '0;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
            cause_q   <= 2'b01;
            div_cnt_q <= '0;
            en_q      <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            str_cnt_q <= str_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            stage_q   <= stage_d;
            rstn_q    <= rstn_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            cause_q   <= cause_d;
            div_cnt_q <= div_cnt_d;
            en_q      <= en_d;
        end
    end

    assign rstn_o     = rstn_q;
    assign rst_busy   = busy_q;
    assign clk_en     = en_q;
    assign sw_rst_ack = ack_q;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: outputs are predicted from the release-time formulas
// (edge of STRETCH entry plus stretch and gap offsets), under directed and random stimulus.
module tb_rst_sequencer;

    localparam int SYNC_DEPTH = 2;
    localparam int STRETCH    = 4;
    localparam int STAGES     = 3;
    localparam int STAGE_GAP  = 2;
    localparam int DIV        = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              sw_rst_req = 1'b0;
    logic              wdt_bite = 1'b0;
    logic              sw_rst_ack;
    logic [STAGES-1:0] rstn_o;
    logic              rst_busy;
    logic              clk_en;
    logic [1:0]        rst_cause;

    int vectors = 0;
    int errs    = 0;

    // reference model: edge count, first high-sampled edge, STRETCH entry edge
    int n        = 0;
    int e0       = -1;
    int s        = -1;
    int cause    = 1;
    int ack_edge = -1;

    rst_sequencer #(
        .SYNC_DEPTH(SYNC_DEPTH), .STRETCH(STRETCH), .STAGES(STAGES),
        .STAGE_GAP(STAGE_GAP), .DIV(DIV)
    ) dut (
        .clk(clk), .resetn(resetn), .sw_rst_req(sw_rst_req), .wdt_bite(wdt_bite),
        .sw_rst_ack(sw_rst_ack), .rstn_o(rstn_o), .rst_busy(rst_busy),
        .clk_en(clk_en), .rst_cause(rst_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    function automatic bit rel(input int m, input int k);
        return (s >= 0) && (m >= s + STRETCH + k * STAGE_GAP);
    endfunction

    function automatic logic [STAGES-1:0] exp_rstn();
        logic [STAGES-1:0] r;
        for (int k = 0; k < STAGES; k++) r[k] = rel(n, k);
        return r;
    endfunction

    function automatic bit exp_en();
        if (!rel(n, 0)) return 1'b0;
        return ((n - (s + STRETCH)) % DIV) == DIV - 1;
    endfunction

    task automatic check_all();
        chk("rstn_o", 32'(rstn_o), 32'(exp_rstn()));
        chk("rst_busy", 32'(rst_busy), 32'(!rel(n, STAGES - 1)));
        chk("clk_en", 32'(clk_en), 32'(exp_en()));
        chk("sw_rst_ack", 32'(sw_rst_ack), 32'(n == ack_edge));
        chk("rst_cause", 32'(rst_cause), 32'(cause));
    endtask

    task automatic model_edge();
        if (!resetn) return;
        if (e0 < 0) begin
            e0 = n;
            s  = n + SYNC_DEPTH;
        end else if (rel(n - 1, STAGES - 1) && (wdt_bite || sw_rst_req)) begin
            cause    = wdt_bite ? 3 : 2;
            ack_edge = (cause == 2) ? n + 1 : -1;
            s        = n + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        model_edge();
        #1;
        check_all();
    endtask

    // async assert mid-cycle and verify the outputs before any clock edge
    task automatic por_assert(input int hold);
        #2;
        resetn   = 1'b0;
        e0       = -1;
        s        = -1;
        cause    = 1;
        ack_edge = -1;
        #1;
        check_all();
        repeat (hold) tick();
        resetn = 1'b1;
    endtask

    task automatic wait_run();
        int guard = 0;
        while (!rel(n - 1, STAGES - 1) && guard < 100) begin
            tick();
            guard++;
        end
        chk("wait_run_timeout", 32'(guard < 100), 32'd1);
    endtask

    initial begin
        int f1 = -1;
        int f3 = -1;
        int guard;

        // reset state
        #2;
        resetn = 1'b0;
        #1;
        check_all();
        repeat (3) tick();
        resetn = 1'b1;

        // POR timing with explicit release edges
        for (int i = 0; i < 14; i++) begin
            tick();
            if (f1 < 0 && rstn_o == 3'b001) f1 = n;
            if (f3 < 0 && rstn_o == 3'b111) f3 = n;
        end
        chk("por_stage0_edge", 32'(f1 - e0), 32'd6);
        chk("por_stage2_edge", 32'(f3 - e0), 32'd10);

        // software reset, request dropped on ack
        wait_run();
        sw_rst_req = 1'b1;
        tick();
        tick();
        chk("sw_ack_seen", 32'(sw_rst_ack), 32'd1);
        sw_rst_req = 1'b0;
        repeat (14) tick();

        // watchdog and software together, request held through the second reset
        wait_run();
        sw_rst_req = 1'b1;
        wdt_bite   = 1'b1;
        tick();
        wdt_bite = 1'b0;
        chk("wdt_cause", 32'(rst_cause), 32'd3);
        guard = 0;
        while (ack_edge < 0 && guard < 60) begin tick(); guard++; end
        while (n < ack_edge && guard < 60) begin tick(); guard++; end
        chk("second_ack_timeout", 32'(guard < 60), 32'd1);
        sw_rst_req = 1'b0;
        repeat (14) tick();

        // watchdog during RELEASE is dropped; then async reset mid-RELEASE
        por_assert(2);
        guard = 0;
        while (!(s >= 0 && n == s + STRETCH + 1) && guard < 40) begin tick(); guard++; end
        wdt_bite = 1'b1;
        tick();
        wdt_bite = 1'b0;
        guard = 0;
        while (!(s >= 0 && n == s + STRETCH + 2 * STAGE_GAP - 1) && guard < 40) begin tick(); guard++; end
        chk("mid_release_pattern", 32'(rstn_o), 32'b011);
        por_assert(1);
        repeat (16) tick();

        // random mix
        for (int i = 0; i < 3000; i++) begin
            wdt_bite = ($urandom_range(0, 15) == 0);
            if (!sw_rst_req && $urandom_range(0, 23) == 0) sw_rst_req = 1'b1;
            if ($urandom_range(0, 399) == 0) por_assert($urandom_range(1, 3));
            tick();
            if (n == ack_edge) sw_rst_req = 1'b0;
        end
        wdt_bite = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
